// File: rtl/cpstr_pkg.sv
// Shared definitions for the control-port stream blocks: escape byte default,
// escaper FSM state encoding and a width helper for grant indices.
package cpstr_pkg;

    localparam logic [7:0] ESC_CHAR_DEFAULT = 8'd27;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ESC_DATA = 2'd1,
        ST_MAIN_DUP = 2'd2
    } state_e;

    // Bits needed to index 'value' items; never less than 1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/cpstr_skid.sv
// Two-entry skid buffer with a fully registered output; input ready depends
// only on the local fill level, so no combinational path reaches the sink.
module cpstr_skid #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign o_ready = (count_q != 2'd2);
    assign o_valid = (count_q != 2'd0);
    assign o_data  = head_q;

    always_comb begin
        push    = i_valid && o_ready;
        pop     = o_valid && i_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = i_data;
                else                 tail_d = i_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous pop and push keeps the level; the oldest entry advances.
                if (count_q == 2'd1) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpstr_esc_mux.sv
// Control-port stream escaper: doubles ESC_CHAR in the main stream and merges
// NUM_ESC out-of-band channels as ESC_CHAR+byte pairs into one registered output.
module cpstr_esc_mux
    import cpstr_pkg::*;
#(
    parameter logic [7:0] ESC_CHAR = ESC_CHAR_DEFAULT,
    parameter int         NUM_ESC  = 2,
    parameter bit         ARB_RR   = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [7:0]           i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [8*NUM_ESC-1:0] i_esc_data,
    input  logic [NUM_ESC-1:0]   i_esc_valid,
    output logic [NUM_ESC-1:0]   o_esc_ready,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output state_e               o_state
);

    localparam int GW = clog2(NUM_ESC);

    // All handshakes: a byte moves on a rising edge where valid and ready are
    // both high; a source holds valid and data steady until that edge.
    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   arb_grant;
    logic [GW-1:0]   cand;
    int              cand_int;
    logic            arb_found;
    logic [7:0]      esc_bytes [NUM_ESC];
    logic [7:0]      s_data;
    logic            s_valid;
    logic            s_ready;

    assign o_state = state_q;

    always_comb begin
        for (int k = 0; k < NUM_ESC; k++) esc_bytes[k] = i_esc_data[8*k +: 8];
    end

    // Search starts at the round-robin pointer (or channel 0) and wraps.
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        cand      = '0;
        cand_int  = 0;
        for (int i = 0; i < NUM_ESC; i++) begin
            cand_int = (ARB_RR ? int'(rr_q) : 0) + i;
            if (cand_int >= NUM_ESC) cand_int = cand_int - NUM_ESC;
            cand = GW'(cand_int);
            if (!arb_found && i_esc_valid[cand]) begin
                arb_found = 1'b1;
                arb_grant = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        s_data      = '0;
        s_valid     = 1'b0;
        o_ready     = 1'b0;
        o_esc_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (|i_esc_valid) begin
                    s_data  = ESC_CHAR;
                    s_valid = 1'b1;
                    if (s_ready) begin
                        state_d = ST_ESC_DATA;
                        grant_d = arb_grant;
                    end
                end else if (i_valid && (i_data == ESC_CHAR)) begin
                    // Prefix only; the main byte itself is taken in MAIN_DUP.
                    s_data  = ESC_CHAR;
                    s_valid = 1'b1;
                    if (s_ready) state_d = ST_MAIN_DUP;
                end else begin
                    s_data  = i_data;
                    s_valid = i_valid;
                    o_ready = s_ready;
                end
            end
            ST_ESC_DATA: begin
                s_data               = esc_bytes[grant_q];
                s_valid              = i_esc_valid[grant_q];
                o_esc_ready[grant_q] = s_ready;
                if (s_valid && s_ready) begin
                    state_d = ST_IDLE;
                    if (ARB_RR) rr_d = (grant_q == GW'(NUM_ESC - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            ST_MAIN_DUP: begin
                s_data  = i_data;
                s_valid = i_valid;
                o_ready = s_ready;
                if (s_valid && s_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!i_rst_n) begin
            o_ready     = 1'b0;
            o_esc_ready = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    cpstr_skid #(.W(8)) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (s_data),
        .i_valid (s_valid),
        .o_ready (s_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

endmodule

// File: tb/tb_cpstr_esc_mux.sv
// Bench for cpstr_esc_mux: a fixed-priority and a round-robin instance driven by
// queue-based sources, checked against directed sequences and a byte-stream model.
module tb_cpstr_esc_mux;
    import cpstr_pkg::*;

    localparam logic [7:0] ESC = 8'h1B;

    logic       clk;
    logic       rst_n;
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_ready [2];
    logic [15:0] e_data [2];
    logic [1:0] e_valid [2];
    logic [1:0] e_ready [2];
    logic [7:0] o_data  [2];
    logic       o_valid [2];
    logic       s_rdy   [2];
    state_e     st      [2];

    logic [7:0] main_src [2][$];
    logic [7:0] esc_src  [2][2][$];
    logic [7:0] exp_q    [2][$];
    logic [7:0] got_q    [2][$];

    int         n_tests, n_fail;
    bit         use_model, rdy_toggle;
    int         valid_pct, rdy_pct;
    logic [7:0] m_trace, e_trace;
    int         m_trace_n, e_trace_n;

    cpstr_esc_mux #(.ESC_CHAR(ESC), .NUM_ESC(2), .ARB_RR(1'b0)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_data(m_data[0]), .i_valid(m_valid[0]), .o_ready(m_ready[0]),
        .i_esc_data(e_data[0]), .i_esc_valid(e_valid[0]), .o_esc_ready(e_ready[0]),
        .o_data(o_data[0]), .o_valid(o_valid[0]), .i_ready(s_rdy[0]),
        .o_state(st[0])
    );

    cpstr_esc_mux #(.ESC_CHAR(ESC), .NUM_ESC(2), .ARB_RR(1'b1)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_data(m_data[1]), .i_valid(m_valid[1]), .o_ready(m_ready[1]),
        .i_esc_data(e_data[1]), .i_esc_valid(e_valid[1]), .o_esc_ready(e_ready[1]),
        .o_data(o_data[1]), .o_valid(o_valid[1]), .i_ready(s_rdy[1]),
        .o_state(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then update sources after the edge.
    task automatic step();
        bit         acc_m [2];
        logic [1:0] acc_e [2];
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_eq("ready_onehot", 32'($countones({m_ready[u], e_ready[u]}) <= 1), 32'd1);
            acc_m[u] = m_valid[u] && m_ready[u];
            acc_e[u] = e_valid[u] & e_ready[u];
            if (o_valid[u] && s_rdy[u]) got_q[u].push_back(o_data[u]);
            if (use_model && acc_m[u]) begin
                if (m_data[u] == ESC) exp_q[u].push_back(ESC);
                exp_q[u].push_back(m_data[u]);
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (use_model && acc_e[u][ch]) begin
                    exp_q[u].push_back(ESC);
                    exp_q[u].push_back(e_data[u][8*ch +: 8]);
                end
            end
        end
        if (m_valid[0]) begin
            m_trace = {m_trace[6:0], m_ready[0]};
            m_trace_n++;
        end
        if (|e_valid[0]) begin
            e_trace = {e_trace[5:0], e_ready[0]};
            e_trace_n++;
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            if (acc_m[u]) begin
                void'(main_src[u].pop_front());
                m_valid[u] = 1'b0;
            end
            if (!m_valid[u] && main_src[u].size() > 0 && $urandom_range(99) < valid_pct) begin
                m_valid[u] = 1'b1;
                m_data[u]  = main_src[u][0];
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (acc_e[u][ch]) begin
                    void'(esc_src[u][ch].pop_front());
                    e_valid[u][ch] = 1'b0;
                end
                if (!e_valid[u][ch] && esc_src[u][ch].size() > 0 && $urandom_range(99) < valid_pct) begin
                    e_valid[u][ch]         = 1'b1;
                    e_data[u][8*ch +: 8]   = esc_src[u][ch][0];
                end
            end
            s_rdy[u] = rdy_toggle ? !s_rdy[u] : ($urandom_range(99) < rdy_pct);
        end
    endtask

    function automatic bit all_idle();
        for (int u = 0; u < 2; u++) begin
            if (main_src[u].size() > 0 || m_valid[u] || o_valid[u]) return 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                if (esc_src[u][ch].size() > 0 || e_valid[u][ch]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!all_idle() && n < budget);
        if (!all_idle()) check_eq("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_out(input int u, input string tag);
        check_eq({tag, "_len"}, got_q[u].size(), exp_q[u].size());
        for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            check_eq(tag, 32'(got_q[u][i]), 32'(exp_q[u][i]));
        end
        got_q[u].delete();
        exp_q[u].delete();
    endtask

    task automatic check_quiet_reset(input string tag);
        for (int u = 0; u < 2; u++) begin
            check_eq({tag, "_ovalid"}, 32'(o_valid[u]), 32'd0);
            check_eq({tag, "_odata"}, 32'(o_data[u]), 32'd0);
            check_eq({tag, "_oready"}, 32'(m_ready[u]), 32'd0);
            check_eq({tag, "_escready"}, 32'(e_ready[u]), 32'd0);
            check_eq({tag, "_state"}, 32'(st[u]), 32'(ST_IDLE));
        end
    endtask

    initial begin
        logic [7:0] b;
        n_tests = 0;
        n_fail = 0;
        use_model = 1'b0;
        rdy_toggle = 1'b0;
        valid_pct = 100;
        rdy_pct = 100;
        m_trace = '0;
        e_trace = '0;
        m_trace_n = 0;
        e_trace_n = 0;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_data[u] = '0;
            m_valid[u] = 1'b0;
            e_data[u] = '0;
            e_valid[u] = '0;
            s_rdy[u] = 1'b1;
        end

        // Clock and reset
        repeat (3) @(posedge clk);
        #1;
        check_quiet_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Main stream only: ESC_CHAR doubled, o_ready low on the prefix cycle
        for (int u = 0; u < 2; u++) begin
            main_src[u] = {8'h41, 8'h1B, 8'h42};
            exp_q[u] = {8'h41, 8'h1B, 8'h1B, 8'h42};
        end
        m_trace = '0;
        m_trace_n = 0;
        run_until_idle(50);
        compare_out(0, "main_fp");
        compare_out(1, "main_rr");
        check_eq("main_rdy_n", m_trace_n, 32'd4);
        check_eq("main_rdy_pat", 32'(m_trace[3:0]), 32'b1011);

        // Single escape on channel 1
        for (int u = 0; u < 2; u++) begin
            esc_src[u][1] = {8'h05};
            exp_q[u] = {ESC, 8'h05};
        end
        e_trace = '0;
        e_trace_n = 0;
        run_until_idle(50);
        compare_out(0, "esc1_fp");
        compare_out(1, "esc1_rr");
        check_eq("esc1_rdy_n", e_trace_n, 32'd2);
        check_eq("esc1_rdy_pat", 32'(e_trace[3:0]), 32'b0010);

        // Arbitration: channel 0 requests twice, channel 1 once
        for (int u = 0; u < 2; u++) begin
            esc_src[u][0] = {8'h10, 8'h10};
            esc_src[u][1] = {8'h20};
        end
        exp_q[0] = {ESC, 8'h10, ESC, 8'h10, ESC, 8'h20};
        exp_q[1] = {ESC, 8'h10, ESC, 8'h20, ESC, 8'h10};
        run_until_idle(50);
        compare_out(0, "arb_fixed");
        compare_out(1, "arb_rr");

        // Escape request arriving while a main ESC pair is half sent
        for (int u = 0; u < 2; u++) main_src[u] = {8'h1B};
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            esc_src[u][0].push_back(8'h33);
            e_valid[u][0] = 1'b1;
            e_data[u][7:0] = 8'h33;
            exp_q[u] = {ESC, ESC, ESC, 8'h33};
        end
        run_until_idle(50);
        compare_out(0, "midpair_fp");
        compare_out(1, "midpair_rr");

        // Alternating output ready during a main burst
        main_src[0] = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_q[0] = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        rdy_toggle = 1'b1;
        s_rdy[0] = 1'b1;
        run_until_idle(100);
        rdy_toggle = 1'b0;
        compare_out(0, "toggle");

        // Output stalled: two bytes fit, then the main stream is refused
        rdy_pct = 0;
        main_src[0] = {8'hA1, 8'hA2, 8'hA3};
        repeat (4) step();
        check_eq("full_oready", 32'(m_ready[0]), 32'd0);
        check_eq("full_ovalid", 32'(o_valid[0]), 32'd1);
        check_eq("full_head", 32'(o_data[0]), 32'hA1);
        rdy_pct = 100;
        exp_q[0] = {8'hA1, 8'hA2, 8'hA3};
        run_until_idle(50);
        compare_out(0, "full");

        // Randomized traffic against the byte-stream model
        use_model = 1'b1;
        valid_pct = 60;
        rdy_pct = 70;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 40; i++) begin
                b = ($urandom_range(3) == 0) ? ESC : 8'($urandom_range(255));
                main_src[u].push_back(b);
            end
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < 10; i++) esc_src[u][ch].push_back(8'($urandom_range(255)));
            end
        end
        run_until_idle(4000);
        use_model = 1'b0;
        valid_pct = 100;
        rdy_pct = 100;
        compare_out(0, "rand_fp");
        compare_out(1, "rand_rr");

        // Reset in the middle of a main ESC pair
        main_src[0] = {8'h1B};
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_quiet_reset("midrst");
        main_src[0].delete();
        m_valid[0] = 1'b0;
        got_q[0].delete();
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        main_src[0] = {8'h1B, 8'h41};
        exp_q[0] = {ESC, ESC, 8'h41};
        run_until_idle(50);
        compare_out(0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpstr_esc_mux.md
Name: cpstr_esc_mux

Overview:
- Multi-channel control-port stream escaper.
- Passes the main byte stream through and doubles any ESC_CHAR byte.
- Arbitrates NUM_ESC out-of-band escape channels onto the same output. Each escape byte is sent as the two-byte sequence ESC_CHAR then byte.
- Sits between the control-port TX framer and the UART/FT245 byte sink. Its registered output stage breaks the combinational valid/ready path to the sink.

Parameters:
- ESC_CHAR, 8'd27, escape byte value.
- NUM_ESC, 2, number of escape channels (1..8).
- ARB_RR, 0, escape arbitration: 0 = fixed priority (channel 0 highest), 1 = round-robin.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_data  in  8  main stream data
- i_valid  in  1  main stream valid
- o_ready  out  1  main stream ready
- i_esc_data  in  8*NUM_ESC  escape data; channel k occupies bits [8k+7:8k]
- i_esc_valid  in  NUM_ESC  per-channel escape valid
- o_esc_ready  out  NUM_ESC  per-channel escape ready, one-hot or zero
- o_data  out  8  output data, registered
- o_valid  out  1  output valid, registered
- i_ready  in  1  output ready

Behaviour:
- Handshakes: all streams are valid/ready. A transfer occurs when valid and ready are both high on a clock edge. Sources hold valid and data stable until accepted.
- Internal stream (s_data, s_valid, s_ready) is driven by the FSM into a 2-entry skid buffer that drives o_data/o_valid.
- s_ready = skid not full.
- Latency: 1 cycle from internal accept to o_valid.
- Throughput: 1 byte/cycle while i_ready stays high.
- FSM states:
  - IDLE:
    - Any i_esc_valid: select grant g via the arbiter. Emit ESC_CHAR; on s accept go to ESC_DATA(g).
    - Else i_valid with i_data==ESC_CHAR: emit ESC_CHAR; on accept go to MAIN_DUP.
    - Else: route main straight through (s_valid=i_valid, o_ready=s_ready); stay in IDLE.
  - ESC_DATA(g): emit i_esc_data[g], s_valid=i_esc_valid[g], o_esc_ready[g]=s_ready. On accept go to IDLE; in round-robin mode set the RR pointer to g+1 mod NUM_ESC.
  - MAIN_DUP: emit i_data (the ESC_CHAR byte), o_ready=s_ready. On accept go to IDLE.
- Grant g is latched when the prefix is accepted and held until the data byte is accepted. A higher-priority request arriving mid-sequence never splits a pair.
- Escape priority: escape requests beat the main stream only in IDLE. A pending main ESC_CHAR pair (MAIN_DUP) completes before any escape is granted.
- o_ready and o_esc_ready are combinational from FSM state and s_ready. At most one of them is high per cycle.
- Escape byte equal to ESC_CHAR: forwarded unchanged (ESC ESC on the wire). Avoiding this value is the source's responsibility.
- Round-robin: search starts at the RR pointer and wraps modulo NUM_ESC. The pointer is unchanged in fixed-priority mode.
- Reset (async assert, sync deassert): FSM=IDLE, skid buffer emptied, o_valid=0, o_data=0, RR pointer=0. During reset o_ready=0 and o_esc_ready=0.
- A reset mid-pair drops the partial sequence. The downstream decoder resynchronises.
- i_ready low: skid holds up to 2 bytes, then s_ready drops, so o_ready and o_esc_ready drop. No byte is lost or duplicated.

Decomposition:
- Shared package cpstr_pkg: ESC_CHAR default, FSM state encoding (ST_IDLE, ST_ESC_DATA, ST_MAIN_DUP), and a clog2 helper for grant width.
- One sub-module: cpstr_skid (2-entry skid buffer, 8-bit, same clock/reset). It is reusable by the other cpstr blocks.

Test Plan:
- Main only: i_data 0x41,0x1B,0x42 with i_ready=1 -> o_data 0x41,0x1B,0x1B,0x42. o_ready low exactly the cycle the first 0x1B prefix is emitted.
- Single escape: ch1 sends 0x05 while main idle -> o_data 0x1B,0x05. o_esc_ready=2'b10 in the data-byte cycle only.
- Fixed priority: ch0=0x10 and ch1=0x20 both valid, ARB_RR=0 -> 0x1B,0x10,0x1B,0x20.
- Round-robin: same stimulus repeated, ARB_RR=1 -> grants alternate: 0x1B,0x10,0x1B,0x20,0x1B,0x10.
- Mid-pair contention: main 0x1B accepted as prefix, then ch0 raises 0x33 -> 0x1B,0x1B,0x1B,0x33, with no interleaving inside a pair.
- Backpressure and reset: i_ready toggles 1010 during main burst 0x01..0x08 -> exact sequence preserved. Assert i_rst_n=0 mid-pair -> o_valid=0 the same cycle; after release, the next byte starts from IDLE.
